scroll_addr_gen: RTL and testbench

- Address-generation stage that feeds the 320x240 12-bit image BRAM; sits between the VGA timing counters and the BRAM address port.
- Maps each 640x480 screen coordinate to a 2x-upscaled image address with a per-frame scroll offset.
- The offset is driven by a small run/pause/bounce state machine.
- Also delays the timing valid so it lines up with the BRAM's registered read data.

---
 rtl/scroll_addr_gen.sv | 133 +++++++++++++
 tb/tb_scroll_addr_gen.sv | 370 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/scroll_addr_gen.sv
// Address generator for a 2x-upscaled 320x240 image behind a 640x480 VGA raster,
// with a per-frame scroll offset driven by a run/pause/bounce state machine.
module scroll_addr_gen #(
    parameter int IMG_W    = 320,
    parameter int IMG_H    = 240,
    parameter int ADDR_W   = 17,
    parameter int V_ACTIVE = 480,
    parameter int STEP_W   = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [9:0]        h_cnt,
    input  logic [9:0]        v_cnt,
    input  logic              valid,
    input  logic              en,
    input  logic              bounce,
    input  logic              axis,
    input  logic [STEP_W-1:0] speed,
    output logic [ADDR_W-1:0] pixel_addr,
    output logic              valid_out,
    output logic              frame_tick,
    output logic [8:0]        offset
);

    typedef enum logic [1:0] {IDLE, RUN_FWD, RUN_REV} state_t;

    state_t      state, next_state;
    logic [8:0]  off_q, next_off;
    logic        axis_q, next_axis;
    logic        valid_d;
    logic        tick_cond;
    logic [8:0]  limit;
    logic [9:0]  sum;
    logic [8:0]  wrapped;
    logic [9:0]  ix_sum, iy_sum;
    logic [8:0]  ix_img, iy_img;
    logic [ADDR_W-1:0] addr_next;
    logic        unused_lsb;

    assign unused_lsb = h_cnt[0] ^ v_cnt[0];
    assign tick_cond  = (h_cnt == 10'd0) && (v_cnt == 10'(V_ACTIVE));

    // axis_q is the axis latched at a frame boundary, so a mid-frame axis flip never tears
    assign limit   = axis_q ? 9'(IMG_H) : 9'(IMG_W);
    assign sum     = {1'b0, off_q} + 10'(speed);
    assign wrapped = (sum >= {1'b0, limit}) ? 9'(sum - {1'b0, limit}) : sum[8:0];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= IDLE;
            off_q  <= '0;
            axis_q <= 1'b0;
        end else begin
            state  <= next_state;
            off_q  <= next_off;
            axis_q <= next_axis;
        end
    end

    always_comb begin
        next_state = state;
        next_off   = off_q;
        next_axis  = axis_q;
        case (state)
            IDLE: begin
                if (en)
                    next_state = RUN_FWD;
            end
            RUN_FWD, RUN_REV: begin
                // pause takes priority over a coincident frame tick
                if (!en) begin
                    next_state = IDLE;
                end else if (frame_tick) begin
                    if (axis != axis_q) begin
                        next_axis  = axis;
                        next_off   = '0;
                        next_state = RUN_FWD;
                    end else if (state == RUN_REV && bounce) begin
                        if (speed != '0) begin
                            if ({1'b0, off_q} <= 10'(speed)) begin
                                next_off   = '0;
                                next_state = RUN_FWD;
                            end else begin
                                next_off = off_q - 9'(speed);
                            end
                        end
                    end else begin
                        next_state = RUN_FWD;
                        if (bounce && speed != '0 && sum >= {1'b0, limit} - 10'd1) begin
                            next_off   = limit - 9'd1;
                            next_state = RUN_REV;
                        end else begin
                            next_off = wrapped;
                        end
                    end
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        offset = off_q;
    end

    // operands stay below twice the limit, so one conditional subtract is a full modulo
    always_comb begin
        ix_sum = {1'b0, h_cnt[9:1]} + {1'b0, off_q};
        iy_sum = {1'b0, v_cnt[9:1]} + {1'b0, off_q};
        ix_img = h_cnt[9:1];
        iy_img = v_cnt[9:1];
        if (!axis_q)
            ix_img = (ix_sum >= 10'(IMG_W)) ? 9'(ix_sum - 10'(IMG_W)) : ix_sum[8:0];
        else
            iy_img = (iy_sum >= 10'(IMG_H)) ? 9'(iy_sum - 10'(IMG_H)) : iy_sum[8:0];
        addr_next = ADDR_W'(iy_img) * ADDR_W'(IMG_W) + ADDR_W'(ix_img);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pixel_addr <= '0;
            valid_d    <= 1'b0;
            valid_out  <= 1'b0;
            frame_tick <= 1'b0;
        end else begin
            pixel_addr <= valid ? addr_next : '0;
            valid_d    <= valid;
            valid_out  <= valid_d;
            frame_tick <= tick_cond;
        end
    end

endmodule

// File: tb/tb_scroll_addr_gen.sv
// Self-checking bench for scroll_addr_gen: scenario tasks plus randomized frames
// compared against a behavioural model of offsets and address mapping.
module tb_scroll_addr_gen;

    logic        clk = 1'b0;
    logic        rst;
    logic [9:0]  h_cnt, v_cnt;
    logic        valid, en, bounce, axis;
    logic [2:0]  speed;
    logic [16:0] pixel_addr;
    logic        valid_out, frame_tick;
    logic [8:0]  offset;

    int checks = 0;
    int errors = 0;

    int m_off, m_axis, m_dir, m_addr;
    bit m_run, m_tick, m_v1, m_v2;

    scroll_addr_gen dut (
        .clk(clk), .rst(rst), .h_cnt(h_cnt), .v_cnt(v_cnt), .valid(valid),
        .en(en), .bounce(bounce), .axis(axis), .speed(speed),
        .pixel_addr(pixel_addr), .valid_out(valid_out),
        .frame_tick(frame_tick), .offset(offset)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_off = 0; m_axis = 0; m_dir = 1; m_addr = 0;
        m_run = 0; m_tick = 0; m_v1 = 0; m_v2 = 0;
    endtask

    function automatic int map_addr(int h, int v, bit val, int off, int ax);
        int x, y;
        if (!val) return 0;
        x = h / 2;
        y = v / 2;
        if (ax == 0) x = (x + off) % 320;
        else         y = (y + off) % 240;
        return y * 320 + x;
    endfunction

    task automatic model_fsm();
        int lim;
        int spd;
        spd = int'(speed);
        lim = (m_axis == 0) ? 320 : 240;
        if (!m_run) begin
            if (en) begin m_run = 1; m_dir = 1; end
        end else if (!en) begin
            m_run = 0;
        end else if (m_tick) begin
            if (int'(axis) != m_axis) begin
                m_axis = int'(axis); m_off = 0; m_dir = 1;
            end else if (m_dir < 0 && bounce) begin
                if (spd > 0) begin
                    if (m_off <= spd) begin m_off = 0; m_dir = 1; end
                    else m_off = m_off - spd;
                end
            end else begin
                m_dir = 1;
                if (bounce && spd > 0 && m_off + spd >= lim - 1) begin
                    m_off = lim - 1; m_dir = -1;
                end else begin
                    m_off = (m_off + spd) % lim;
                end
            end
        end
    endtask

    task automatic step(input int h, input int v, input bit val);
        int nxt;
        h_cnt = 10'(h);
        v_cnt = 10'(v);
        valid = val;
        nxt = map_addr(h, v, val, m_off, m_axis);
        model_fsm();
        @(posedge clk); #1;
        m_addr = nxt;
        m_v2 = m_v1;
        m_v1 = val;
        m_tick = (h == 0 && v == 480);
    endtask

    task automatic tick_frame();
        step(0, 480, 0);
        step(2, 480, 0);
    endtask

    task automatic test_reset();
        rst = 1'b0; en = 0; bounce = 0; axis = 0; speed = 0;
        for (int i = 0; i < 3; i++) begin
            h_cnt = 10'($urandom_range(639));
            v_cnt = 10'($urandom_range(479));
            valid = 1'b1;
            @(posedge clk); #1;
            checks++;
            if (pixel_addr !== 17'd0 || valid_out !== 1'b0 || offset !== 9'd0 || frame_tick !== 1'b0) begin
                errors++;
                $display("[TB] FAIL reset_hold addr=%0d vout=%0b off=%0d tick=%0b required all 0",
                         pixel_addr, valid_out, offset, frame_tick);
            end
        end
        rst = 1'b1;
        model_reset();
        for (int f = 0; f < 3; f++) begin
            tick_frame();
            checks++;
            if (offset !== 9'd0) begin
                errors++;
                $display("[TB] FAIL idle_offset frame %0d got %0d required 0", f, offset);
            end
        end
    endtask

    task automatic test_static();
        int hs[4]   = '{0, 1, 2, 639};
        int vs[4]   = '{0, 0, 0, 479};
        int exps[4] = '{0, 0, 1, 76799};
        bit vexp[4] = '{0, 1, 1, 1};
        step(700, 100, 0);
        step(700, 100, 0);
        for (int i = 0; i < 4; i++) begin
            step(hs[i], vs[i], 1);
            checks++;
            if (pixel_addr !== 17'(exps[i])) begin
                errors++;
                $display("[TB] FAIL static_addr (%0d,%0d) got %0d required %0d", hs[i], vs[i], pixel_addr, exps[i]);
            end
            checks++;
            if (valid_out !== vexp[i]) begin
                errors++;
                $display("[TB] FAIL static_vout idx %0d got %0b required %0b", i, valid_out, vexp[i]);
            end
        end
        step(700, 0, 0);
        checks++;
        if (pixel_addr !== 17'd0 || valid_out !== 1'b1) begin
            errors++;
            $display("[TB] FAIL blank_addr got addr=%0d vout=%0b required addr=0 vout=1", pixel_addr, valid_out);
        end
        step(700, 0, 0);
        checks++;
        if (valid_out !== 1'b0) begin
            errors++;
            $display("[TB] FAIL vout_fall got %0b required 0", valid_out);
        end
    endtask

    task automatic test_wrap();
        en = 1; axis = 0; bounce = 0; speed = 3'd4;
        step(700, 490, 0);
        for (int f = 1; f <= 79; f++) begin
            tick_frame();
            if (f <= 3 || f == 79) begin
                checks++;
                if (offset !== 9'(4 * f)) begin
                    errors++;
                    $display("[TB] FAIL wrap_offset frame %0d got %0d required %0d", f, offset, 4 * f);
                end
            end
        end
        step(0, 0, 1);
        checks++;
        if (pixel_addr !== 17'd316) begin
            errors++;
            $display("[TB] FAIL wrap_addr_before got %0d required 316", pixel_addr);
        end
        tick_frame();
        checks++;
        if (offset !== 9'd0) begin
            errors++;
            $display("[TB] FAIL wrap_to_zero got %0d required 0", offset);
        end
        step(0, 0, 1);
        checks++;
        if (pixel_addr !== 17'd0) begin
            errors++;
            $display("[TB] FAIL wrap_addr_after got %0d required 0", pixel_addr);
        end
    endtask

    task automatic test_bounce();
        int exp_off;
        axis = 1; bounce = 1; speed = 3'd7;
        tick_frame();
        checks++;
        if (offset !== 9'd0) begin
            errors++;
            $display("[TB] FAIL axis_clear got %0d required 0", offset);
        end
        for (int f = 1; f <= 71; f++) begin
            tick_frame();
            if (f <= 34)      exp_off = 7 * f;
            else if (f == 35) exp_off = 239;
            else if (f <= 69) exp_off = 239 - 7 * (f - 35);
            else if (f == 70) exp_off = 0;
            else              exp_off = 7;
            checks++;
            if (offset !== 9'(exp_off)) begin
                errors++;
                $display("[TB] FAIL bounce_offset frame %0d got %0d required %0d", f, offset, exp_off);
            end
            if (f == 35) begin
                step(0, 0, 1);
                checks++;
                if (pixel_addr !== 17'd76480) begin
                    errors++;
                    $display("[TB] FAIL bounce_addr got %0d required 76480", pixel_addr);
                end
            end
        end
    endtask

    task automatic test_frame_count();
        int hs[4] = '{0, 1, 400, 799};
        int ticks = 0;
        bounce = 0; speed = 3'd5;
        for (int v = 0; v < 525; v++) begin
            for (int i = 0; i < 4; i++) begin
                step(hs[i], v, (hs[i] < 640) && (v < 480));
                if (frame_tick === 1'b1) ticks++;
                checks++;
                if (pixel_addr !== 17'(m_addr)) begin
                    errors++;
                    $display("[TB] FAIL scan_addr (%0d,%0d) got %0d required %0d", hs[i], v, pixel_addr, m_addr);
                end
            end
        end
        checks++;
        if (ticks != 1) begin
            errors++;
            $display("[TB] FAIL tick_count got %0d required 1", ticks);
        end
        checks++;
        if (offset !== 9'(m_off)) begin
            errors++;
            $display("[TB] FAIL scan_offset got %0d required %0d", offset, m_off);
        end
    endtask

    task automatic test_pause();
        en = 1; axis = 0; bounce = 0; speed = 3'd3;
        repeat (3) tick_frame();
        checks++;
        if (offset !== 9'd6) begin
            errors++;
            $display("[TB] FAIL pause_start got %0d required 6", offset);
        end
        step(100, 50, 1);
        en = 0;
        step(102, 50, 1);
        repeat (3) tick_frame();
        checks++;
        if (offset !== 9'd6) begin
            errors++;
            $display("[TB] FAIL paused_hold got %0d required 6", offset);
        end
        en = 1;
        step(104, 50, 1);
        tick_frame();
        checks++;
        if (offset !== 9'd9) begin
            errors++;
            $display("[TB] FAIL resume got %0d required 9", offset);
        end
        step(0, 480, 0);
        en = 0;
        step(2, 480, 0);
        checks++;
        if (offset !== 9'd9) begin
            errors++;
            $display("[TB] FAIL pause_vs_tick got %0d required 9", offset);
        end
        en = 1;
        step(700, 490, 0);
        tick_frame();
        checks++;
        if (offset !== 9'd12) begin
            errors++;
            $display("[TB] FAIL resume2 got %0d required 12", offset);
        end
        axis = 1;
        tick_frame();
        checks++;
        if (offset !== 9'd0) begin
            errors++;
            $display("[TB] FAIL axis_toggle got %0d required 0", offset);
        end
        tick_frame();
        checks++;
        if (offset !== 9'd3) begin
            errors++;
            $display("[TB] FAIL new_axis_run got %0d required 3", offset);
        end
    endtask

    task automatic test_async_reset();
        en = 1; bounce = 0; speed = 3'd2;
        step(10, 20, 1);
        step(12, 20, 1);
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if (pixel_addr !== 17'd0 || valid_out !== 1'b0 || offset !== 9'd0 || frame_tick !== 1'b0) begin
            errors++;
            $display("[TB] FAIL async_reset addr=%0d vout=%0b off=%0d tick=%0b required all 0",
                     pixel_addr, valid_out, offset, frame_tick);
        end
        repeat (3) @(posedge clk);
        #3;
        rst = 1'b1;
        model_reset();
        step(4, 2, 1);
        checks++;
        if (pixel_addr !== 17'd322 || valid_out !== 1'b0) begin
            errors++;
            $display("[TB] FAIL post_reset_addr got addr=%0d vout=%0b required addr=322 vout=0", pixel_addr, valid_out);
        end
        step(6, 2, 1);
        checks++;
        if (pixel_addr !== 17'd323 || valid_out !== 1'b1) begin
            errors++;
            $display("[TB] FAIL post_reset_next got addr=%0d vout=%0b required addr=323 vout=1", pixel_addr, valid_out);
        end
    endtask

    task automatic test_random();
        for (int f = 0; f < 40; f++) begin
            en     = ($urandom_range(3) != 0);
            bounce = 1'($urandom_range(1));
            if ($urandom_range(9) == 0) axis = ~axis;
            speed  = 3'($urandom_range(7));
            for (int j = 0; j < 18; j++) begin
                if (j < 15)
                    step(int'($urandom_range(639)), int'($urandom_range(479)), 1'($urandom_range(1)));
                else if (j == 15)
                    step(0, 480, 0);
                else
                    step(6, 480, 0);
                checks++;
                if (pixel_addr !== 17'(m_addr) || valid_out !== m_v2 ||
                    frame_tick !== m_tick || offset !== 9'(m_off)) begin
                    errors++;
                    $display("[TB] FAIL random f%0d c%0d got addr=%0d vout=%0b tick=%0b off=%0d required addr=%0d vout=%0b tick=%0b off=%0d",
                             f, j, pixel_addr, valid_out, frame_tick, offset, m_addr, m_v2, m_tick, m_off);
                end
            end
        end
    endtask

    initial begin
        h_cnt = '0; v_cnt = '0; valid = 0; en = 0; bounce = 0; axis = 0; speed = '0;
        rst = 1'b0;
        model_reset();
        test_reset();
        test_static();
        test_wrap();
        test_bounce();
        test_frame_count();
        test_pause();
        test_async_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
